axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI4-Lite initiator that turns single-beat commands from a local command/response interface into AXI4-Lite write (AW/W/B) or read (AR/R) transactions. It is the bus-driving counterpart to the team's AXI-Lite slave controller and sits between local control logic (sequencers, test engines, CPU-less config loaders) and an AXI-Lite interconnect or slave. It issues exactly one transaction at a time, with no outstanding-transaction overlap.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; a multiple of 8
- aclk  in  1  single clock; all logic on rising edge
- aresetn  in  1  reset is synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted on cmd_valid&&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads
- rsp_valid  out  1  transaction complete, response held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP as received
- awaddr/awvalid out, awready in: AW channel
- wdata/wstrb/wvalid out, wready in: W channel
- bresp/bvalid in, bready out: B channel
- araddr/arvalid out, arready in: AR channel
- rdata/rresp/rvalid in, rready out: R channel

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, latch cmd fields into awaddr/wdata/wstrb (write) or araddr (read). Go to WR_ADDR_DATA with awvalid=wvalid=1, or to RD_ADDR with arvalid=1.
- WR_ADDR_DATA: track aw_done and w_done independently. awvalid drops on the edge after awvalid&&awready, and wvalid drops on the edge after wvalid&&wready. Either order and simultaneous completion are legal. Once both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, latch bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, then go to RSP.
- RD_ADDR: arvalid held until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata and rresp, set rsp_write=0, then go to RSP.
- RSP: rsp_valid=1 and all rsp_* fields are stable. On rsp_ready, go to IDLE.
- AXI rules:
  - A valid, once asserted, never deasserts before its handshake.
  - Payload is stable while valid is high.
  - No valid depends combinationally on a ready.
- cmd_ready, awvalid, wvalid, arvalid, bready, rready and rsp_valid are all registered outputs.
- SLVERR/DECERR are forwarded unchanged and do not alter the flow.

## Timing
- Reset (aresetn=0 at an edge):
  - Next state IDLE.
  - All valids and readies 0, except cmd_ready=1 after reset release.
  - All address, data, strobe, rsp_* outputs 0.
- Reset mid-transaction abandons it; no response is produced.
- Minimum write latency: accept at edge N; AW+W valid from N+1; slave ready at N+1 gives bready from N+2; bvalid at N+2 gives rsp_valid at N+3.
- Minimum read latency: accept at N; arvalid from N+1; rready from N+2; rvalid at N+2 gives rsp_valid at N+3.
- Back-to-back: rsp_ready at edge M returns to IDLE, cmd_ready=1 in cycle M+1, and the next accept at M+1.
- cmd_valid outside IDLE is ignored (not queued).
- Slave stalls of arbitrary length are held indefinitely; there is no timeout.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, slave always ready, bresp=00 -> AW/W both at N+1, rsp_valid at N+3, rsp_resp=00, rsp_write=1, rsp_rdata=0.
- Read addr 0x20, slave returns 0x12345678 with rvalid 4 cycles after arready -> arvalid held until arready; rsp_rdata=0x12345678, rsp_resp=00, rsp_write=0.
- Write with awready 3 cycles after wready (and the reverse order) -> wvalid drops after its own handshake while awvalid is held; exactly one B accepted; rsp_valid once.
- Write with bresp=10, then read with rresp=11 -> rsp_resp=10, then 11; flow unchanged.
- rsp_ready held low 5 cycles with a second cmd_valid pending -> rsp fields stable, cmd_ready=0, second command accepted only the cycle after the rsp handshake.
- aresetn=0 during WR_RESP with bvalid low -> next edge: all valids/readies 0, rsp_valid=0; after release cmd_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one local command becomes one AW/W/B write
// or AR/R read, and the outcome is returned on a held response interface.
`timescale 1ns/1ps
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // Handshakes on every channel: a transfer happens on a rising edge where valid
  // and ready are both 1; a raised valid and its payload hold until that edge.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  state_t                  state, state_n;
  logic                    cmd_ready_n, rsp_valid_n, rsp_write_n;
  logic                    awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0]   wdata_n, rsp_rdata_n;
  logic [DATA_WIDTH/8-1:0] wstrb_n;
  logic [1:0]              rsp_resp_n;

  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready;
    rsp_valid_n = rsp_valid;
    rsp_write_n = rsp_write;
    rsp_rdata_n = rsp_rdata;
    rsp_resp_n  = rsp_resp;
    awaddr_n    = awaddr;
    awvalid_n   = awvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    wvalid_n    = wvalid;
    araddr_n    = araddr;
    arvalid_n   = arvalid;
    bready_n    = bready;
    rready_n    = rready;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            wstrb_n   = cmd_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_ADDR_DATA;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // A low awvalid/wvalid here means that channel has already completed.
        if (awvalid && awready) awvalid_n = 1'b0;
        if (wvalid && wready)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid && bready) begin
          rsp_resp_n  = bresp;
          rsp_rdata_n = '0;
          rsp_write_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_ADDR: begin
        if (arvalid && arready) begin
          arvalid_n = 1'b0;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid && rready) begin
          rsp_resp_n  = rresp;
          rsp_rdata_n = rdata;
          rsp_write_n = 1'b0;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Readies and the response valid follow the state being entered, so they are flops.
    cmd_ready_n = (state_n == IDLE);
    bready_n    = (state_n == WR_RESP);
    rready_n    = (state_n == RD_DATA);
    rsp_valid_n = (state_n == RSP);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_write <= rsp_write_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_resp  <= rsp_resp_n;
      awaddr    <= awaddr_n;
      awvalid   <= awvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      wvalid    <= wvalid_n;
      araddr    <= araddr_n;
      arvalid   <= arvalid_n;
      bready    <= bready_n;
      rready    <= rready_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a vector table drives commands against a
// delay-programmable slave model; reset corners are hand-written sequences.
`timescale 1ns/1ps
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // d_a: AW/AR ready delay, d_w: W ready delay, d_r: B/R valid delay after the address phase.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d_a;
    int          d_w;
    int          d_r;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    logic        keep;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge; slave inputs change only on falling edges.
  task automatic run_vec(input int idx, input vec_t v);
    int k, waitc, lat, viol;
    int n_aw, n_w, n_b, n_ar, n_r, aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_f, w_f, b_f, ar_f, r_f, rsp_f, aw_done, w_done, ar_done, done, unstable;
    bit prev_aw, prev_w, prev_ar;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        s_write;
    logic [19:0] hs;

    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb; rdata = v.rdata;
    @(posedge clk);
    @(negedge clk);
    if (!v.keep) cmd_valid = 1'b0;

    {n_aw, n_w, n_b, n_ar, n_r} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    {aw_f, w_f, b_f, ar_f, r_f, rsp_f, aw_done, w_done, ar_done, done, unstable} = '0;
    {prev_aw, prev_w, prev_ar} = '0;
    lat = 0; viol = 0; k = 1;
    s_rdata = '0; s_resp = '0; s_write = 1'b0;

    while (!done && k < 100) begin
      if (aw_f) begin n_aw++; aw_done = 1; end
      if (w_f)  begin n_w++;  w_done = 1;  end
      if (b_f)  begin n_b++;  bvalid = 1'b0; end
      if (ar_f) begin n_ar++; ar_done = 1; end
      if (r_f)  begin n_r++;  rvalid = 1'b0; end
      if (rsp_f) done = 1;
      if (!done) begin
        if (prev_aw && !aw_f && !awvalid) viol++;
        if (prev_w && !w_f && !wvalid) viol++;
        if (prev_ar && !ar_f && !arvalid) viol++;
        if (awvalid && awaddr !== v.addr) viol++;
        if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) viol++;
        if (arvalid && araddr !== v.addr) viol++;
        if (cmd_ready) viol++;
        if (rsp_valid) begin
          if (lat == 0) begin
            lat = k; s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
          end else if (rsp_rdata !== s_rdata || rsp_resp !== s_resp || rsp_write !== s_write) begin
            unstable = 1;
          end
        end
        awready = awvalid && !aw_done && (aw_cnt >= v.d_a);
        if (awvalid && !aw_done) aw_cnt++;
        wready = wvalid && !w_done && (w_cnt >= v.d_w);
        if (wvalid && !w_done) w_cnt++;
        arready = arvalid && !ar_done && (ar_cnt >= v.d_a);
        if (arvalid && !ar_done) ar_cnt++;
        if (aw_done && w_done && !bvalid && n_b == 0) begin
          if (b_cnt >= v.d_r) begin bvalid = 1'b1; bresp = v.resp; end
          b_cnt++;
        end
        if (ar_done && !rvalid && n_r == 0) begin
          if (r_cnt >= v.d_r) begin rvalid = 1'b1; rresp = v.resp; end
          r_cnt++;
        end
        aw_f = awvalid && awready;
        w_f  = wvalid && wready;
        ar_f = arvalid && arready;
        b_f  = bvalid && bready;
        r_f  = rvalid && rready;
        rsp_ready = rsp_valid && (k >= lat + v.hold);
        rsp_f = rsp_valid && rsp_ready;
        prev_aw = awvalid; prev_w = wvalid; prev_ar = arvalid;
        @(negedge clk);
        k++;
      end
    end
    {awready, wready, arready, bvalid, rvalid, rsp_ready} = '0;
    cmd_valid = 1'b0;

    if (!done) chk($sformatf("v%0d_timeout", idx), 0, 1);
    hs = {n_aw[3:0], n_w[3:0], n_b[3:0], n_ar[3:0], n_r[3:0]};
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_rsp_write", idx), s_write, v.wr);
    chk($sformatf("v%0d_rsp_rdata", idx), s_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_resp", idx), s_resp, v.exp_resp);
    chk($sformatf("v%0d_handshakes", idx), hs, v.wr ? 20'h11100 : 20'h00011);
    chk($sformatf("v%0d_protocol", idx), viol, 0);
    chk($sformatf("v%0d_rsp_stable", idx), unstable, 0);
    chk($sformatf("v%0d_post_rsp", idx), {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'hA5A5A5A5, 0, 1'b0, 3, 32'h0, 2'b00};
    vecs[1] = '{1'b0, 32'h20, 32'h0, 4'h0, 2, 0, 3, 2'b00, 32'h12345678, 0, 1'b0, 8, 32'h12345678, 2'b00};
    vecs[2] = '{1'b1, 32'h34, 32'h11223344, 4'h5, 3, 0, 1, 2'b00, 32'hA5A5A5A5, 0, 1'b0, 7, 32'h0, 2'b00};
    vecs[3] = '{1'b1, 32'h38, 32'h55667788, 4'hA, 0, 3, 0, 2'b00, 32'hA5A5A5A5, 0, 1'b0, 6, 32'h0, 2'b00};
    vecs[4] = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b10, 32'hA5A5A5A5, 0, 1'b0, 3, 32'h0, 2'b10};
    vecs[5] = '{1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 2'b11, 32'h0BADF00D, 0, 1'b0, 3, 32'h0BADF00D, 2'b11};
    vecs[6] = '{1'b0, 32'h48, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h87654321, 5, 1'b1, 3, 32'h87654321, 2'b00};
    vecs[7] = '{1'b1, 32'h4C, 32'h0F0F0F0F, 4'h3, 0, 0, 2, 2'b01, 32'hA5A5A5A5, 0, 1'b0, 5, 32'h0, 2'b01};
    vecs[8] = '{1'b0, 32'h54, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h5A5A0001, 0, 1'b0, 4, 32'h5A5A0001, 2'b00};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 7'b0);
    chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 100'h0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    chk("rst_state", dbg_state, 3'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_release_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while waiting in WR_RESP with bvalid low
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60;
    cmd_wdata = 32'h13572468; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midrst_aw_w_valid", {awvalid, wvalid}, 2'b11);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("midrst_wr_resp", {bready, awvalid, wvalid}, 3'b100);
    aresetn = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 7'b0);
    chk("midrst_data", {awaddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write}, 103'h0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("midrst_release", {cmd_ready, rsp_valid}, 2'b10);
    run_vec(8, vecs[8]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
